// File: rtl/iir_mac_scheduler_if.sv
// iir_mac_scheduler_if: frame-in / frame-out valid-ready bundle for iir_mac_scheduler
//   in_valid/in_ready/in_data    : input frame handshake, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready/out_data : filtered frame handshake, same packing
interface iir_mac_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 2
);
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/iir_mac_scheduler.sv
// iir_mac_scheduler: one shared multiplier/accumulator running a first-order IIR over NUM_CH channels
//   clk_i   : rising-edge clock
//   rst_i   : synchronous active-high reset
//   clear_i : zero all channel histories (honored only in IDLE)
//   bus     : slave side of iir_mac_scheduler_if (input frame in, filtered frame out)
module iir_mac_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 2,
  parameter int QUANT_BITS = 10,
  parameter int B0         = 178,
  parameter int B1         = 178,
  parameter int A1         = -666
) (
  input logic               clk_i,
  input logic               rst_i,
  input logic               clear_i,
  iir_mac_scheduler_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         ch_q, ch_d;
  logic [1:0]            step_q, step_d;
  logic signed [W-1:0]   acc_q;
  logic signed [W-1:0]   x_prev_q [NUM_CH];
  logic signed [W-1:0]   y_prev_q [NUM_CH];
  logic [NUM_CH*W-1:0]   frame_q, out_q;
  logic signed [W-1:0]   coef, opnd, dq, y;
  logic signed [2*W-1:0] prod;
  logic                  last_ch, accept, in_ready, out_valid;
  assign last_ch = ch_q == CW'(NUM_CH - 1);
  assign accept  = in_ready && bus.in_valid;
  // Step selects which coefficient/history pair feeds the shared multiplier.
  always_comb begin
    coef = step_q == 2'd0 ? W'(B0) : step_q == 2'd1 ? W'(B1) : W'(A1);
    opnd = step_q == 2'd0 ? frame_q[int'(ch_q)*W +: W] :
           step_q == 2'd1 ? x_prev_q[ch_q] : y_prev_q[ch_q];
    prod = coef * opnd;
    dq   = W'(prod >>> QUANT_BITS);
    y    = step_q == 2'd0 ? dq : acc_q + dq;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ch_q    <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      step_q  <= step_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    step_d  = step_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = MAC;
        ch_d    = '0;
        step_d  = '0;
      end
      MAC: begin
        step_d = step_q == 2'd2 ? 2'd0 : step_q + 2'd1;
        ch_d   = step_q == 2'd2 && !last_ch ? ch_q + 1'b1 : ch_q;
        if (step_q == 2'd2 && last_ch) state_d = OUT;
      end
      OUT: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state_q == IDLE && !clear_i;
    out_valid = state_q == OUT;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      frame_q <= '0;
      out_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        x_prev_q[c] <= '0;
        y_prev_q[c] <= '0;
      end
    end else begin
      if (accept) frame_q <= bus.in_data;
      if (state_q == IDLE && clear_i)
        for (int c = 0; c < NUM_CH; c++) begin
          x_prev_q[c] <= '0;
          y_prev_q[c] <= '0;
        end
      if (state_q == MAC) begin
        acc_q <= y;
        if (step_q == 2'd2) begin
          out_q[int'(ch_q)*W +: W] <= y;
          x_prev_q[ch_q]           <= frame_q[int'(ch_q)*W +: W];
          y_prev_q[ch_q]           <= y;
        end
      end
    end
  end
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_q;
endmodule

// File: tb/tb_iir_mac_scheduler.sv
// tb_iir_mac_scheduler: directed vectors and corner sequences for iir_mac_scheduler
module tb_iir_mac_scheduler;
  localparam int W = 32;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  always #5 clk = ~clk;
  iir_mac_scheduler_if #(.DATA_WIDTH(W), .NUM_CH(N)) bus ();
  iir_mac_scheduler #(.DATA_WIDTH(W), .NUM_CH(N)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .bus(bus)
  );
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [2*W-1:0] din;
    logic [2*W-1:0] req;
  } vec_t;
  vec_t tbl [4];
  function automatic logic [2*W-1:0] pk(input int c0, input int c1);
    return {c1, c0};
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic send(input logic [2*W-1:0] d, output logic [2*W-1:0] got, output int lat);
    int n = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 50) check("accept_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    got = bus.out_data;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask
  initial begin
    logic [2*W-1:0] got, held;
    int lat, bp_err;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tbl[0] = '{pk(1024, 0),  pk(178, 0)};
    tbl[1] = '{pk(1024, 0),  pk(240, 0)};
    tbl[2] = '{pk(0, 2048),  pk(21, 356)};
    tbl[3] = '{pk(-1024, 0), pk(-192, 124)};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_data", bus.out_data, 64'd0);
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].din, got, lat);
      check($sformatf("vec%0d_data", i), got, tbl[i].req);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd7);
    end
    do_reset();
    send(pk(-1, 5), got, lat);
    check("neg_floor", got, pk(-1, 0));
    do_reset();
    bus.in_data  = pk(1024, 0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_data = pk(5000, 5000);
    repeat (6) @(posedge clk);
    #1 check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    held = bus.out_data;
    check("bp_data", held, pk(178, 0));
    bp_err = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 if (bus.in_ready || !bus.out_valid || bus.out_data !== held) bp_err++;
    end
    check("bp_hold", 64'(bp_err), 64'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    send(pk(1024, 0), got, lat);
    check("bp_single_capture", got, pk(240, 0));
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = pk(1024, 1024);
    #1 check("clear_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1 clear = 1'b0;
    bus.in_valid = 1'b0;
    #1 check("clear_no_accept", 64'(bus.in_ready), 64'd1);
    send(pk(1024, 1024), got, lat);
    check("clear_hist", got, pk(178, 178));
    bus.in_data  = pk(1024, 1024);
    bus.in_valid = 1'b1;
    #1 check("mid_accept_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    send(pk(1024, 0), got, lat);
    check("mid_rst_hist", got, pk(178, 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iir_mac_scheduler.md
# iir_mac_scheduler

Time-multiplexed controller that shares one signed multiplier and one accumulator among NUM_CH channels of the first-order de-emphasis IIR, y[n] = DQ(B0·x[n]) + DQ(B1·x[n-1]) + DQ(A1·y[n-1]). The block sits between the stereo demux (left/right audio) and the audio output stage. It accepts one frame holding one sample per channel and sequences three MAC steps per channel. Per-channel x/y history lives in small register files, and a valid/ready handshake is used on both sides.

## Interface
- DATA_WIDTH, 32: sample and coefficient width, two's complement.
- NUM_CH, 2: channels per frame, ≥1.
- QUANT_BITS, 10: fixed-point fraction bits; DQ(p) = p >>> QUANT_BITS.
- B0, 178: feed-forward coefficient for x[n].
- B1, 178: feed-forward coefficient for x[n-1].
- A1, -666: feedback coefficient for y[n-1], added with its sign.
- clock  in  1  single clock; everything is rising-edge.
- reset  in  1  synchronous, active-high.
- clear  in  1  zeroes all channel histories; honored only in IDLE.
- in_valid  in  1  frame available.
- in_ready  out  1  block can accept a frame.
- in_data  in  NUM_CH·DATA_WIDTH  channel c in bits [c·DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  filtered frame available.
- out_ready  in  1  downstream accepts the frame.
- out_data  out  NUM_CH·DATA_WIDTH  filtered frame, same packing as in_data.

## Operation
- States are IDLE, MAC and OUT. Counters are ch (0..NUM_CH-1) and step (0..2).
- **Reset:**
  - State goes to IDLE; ch and step go to 0.
  - The accumulator, all x_prev[c] and y_prev[c], and out_data go to 0.
  - out_valid is 0.
- **IDLE:**
  - in_ready = !clear.
  - clear high: zero all histories and stay in IDLE. No frame is taken, because in_ready is low.
  - in_valid && in_ready: latch in_data into a frame register, go to MAC with ch=0, step=0.
- **MAC:** one multiply per cycle on the shared multiplier. For the current channel:
  - step 0: acc ← DQ(B0·x[ch]).
  - step 1: acc ← acc + DQ(B1·x_prev[ch]).
  - step 2: y = acc + DQ(A1·y_prev[ch]). Write out_data slot ch ← y, x_prev[ch] ← x[ch], y_prev[ch] ← y.
  - After step 2: step ← 0 and ch ← ch+1. When ch = NUM_CH-1, go to OUT instead.
  - clear and in_valid are ignored in MAC.
- **OUT:**
  - out_valid = 1, and out_data is held stable.
  - On out_ready, go to IDLE.
  - clear is ignored in OUT.
- **Arithmetic:**
  - Each product is the full 2·DATA_WIDTH signed product.
  - DQ is an arithmetic right shift (floor toward −∞), truncated to DATA_WIDTH.
  - Additions are signed and wrap modulo 2^DATA_WIDTH; there is no saturation.
- History for channel c changes only at its own step 2 or on clear/reset. Channels never cross-contaminate.

## Timing
- Frame accepted at edge T (in_ready && in_valid). MAC steps occupy cycles T+1 … T+3·NUM_CH.
- out_valid rises at T+3·NUM_CH+1, giving a latency of 3·NUM_CH+1 cycles. This is 7 for NUM_CH=2.
- Output handshake at edge U: out_valid is low at U+1, and in_ready is high at U+1 unless clear is high.
- Minimum frame period is 3·NUM_CH+2 cycles. in_ready is combinational from state and clear only.
- Backpressure: OUT persists indefinitely, and out_data and histories are frozen.
- Reset mid-MAC or mid-OUT:
  - The partial frame is discarded and histories are zeroed.
  - out_valid is low on the next cycle and in_ready is high.
- in_valid held high while the block is busy does not cause a second capture. Exactly one frame is taken per IDLE handshake.

## Test plan
- **Impulse after reset:** NUM_CH=2, frame {ch0=1024, ch1=0}. Expect out_data {178, 0}, with out_valid exactly 7 cycles after acceptance.
- **History and rounding:** after the impulse, frame {1024, 0}. Expect ch0 = 178+178+DQ(−666·178) = 356−116 = 240, and ch1 = 0.
- **Negative floor:** after reset, frame {−1, 5}. Expect {−1, 0}, since DQ(−178) = −1 and DQ(890) = 0.
- **Backpressure:**
  - Hold out_ready=0 for 20 cycles with in_valid=1 continuously.
  - Expect out_data stable, in_ready low throughout, and no second capture.
  - Release out_ready; expect in_ready high the next cycle.
- **Clear:**
  - After several frames, assert clear in IDLE together with in_valid. Expect no acceptance that cycle and histories zeroed.
  - Then send {1024, 1024}. Expect {178, 178}.
- **Reset mid-MAC:** assert reset 3 cycles after acceptance. Expect out_valid=0 and in_ready=1 next cycle; the following frame {1024, 0} gives {178, 0}.
